// File: rtl/result_accumulator.sv
// Sums consecutive 32-bit pipeline results into groups of up to LEN beats (early close on in_last).
// Latency: closing beat accepted at edge k -> out_valid high from edge k until the output handshake.
// Backpressure: in_ready = (state==ACC) only; HOLD blocks input until out_ready consumes the group.
module result_accumulator #(
    parameter int WIDTH = 32,
    parameter int LEN   = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_sum_q;
    logic [CNT_W-1:0]   out_count_q;
    logic               out_ovf_q;

    // Sum is taken one bit wider so the top bit is the carry out of WIDTH.
    logic [WIDTH:0]     sum_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               close_d;

    assign sum_d   = {1'b0, acc_q} + {1'b0, in_data};
    assign cnt_d   = cnt_q + 1'b1;
    assign close_d = (cnt_d == CNT_W'(LEN)) || in_last;

    assign in_ready  = (state_q == ACC);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (in_valid) begin
                        if (close_d) begin
                            out_sum_q   <= sum_d[WIDTH-1:0];
                            out_count_q <= cnt_d;
                            out_ovf_q   <= ovf_q | sum_d[WIDTH];
                            out_valid_q <= 1'b1;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            ovf_q       <= 1'b0;
                            state_q     <= HOLD;
                        end else begin
                            acc_q       <= sum_d[WIDTH-1:0];
                            cnt_q       <= cnt_d;
                            ovf_q       <= ovf_q | sum_d[WIDTH];
                        end
                    end
                end
                HOLD: begin
                    // Output fields are left untouched after the handshake.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ACC;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end

endmodule
